vga_sync_gen: RTL and testbench

- Timing generator for the VGA display pipeline: produces pixel_x, pixel_y and video_on, which the text and sprite renderers (credit line, title text, invaders) consume, plus hsync/vsync to the VGA connector.
- Derives a pixel-rate enable from the system clock; all renderers sample coordinates on p_tick.
- Default timing is 640x480 at 60 Hz from a 100 MHz clock.

---
 rtl/vga_sync_gen.sv | 120 ++++++++++++
 tb/tb_vga_sync_gen.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-rate tick, h/v counters, registered sync/blank/start decode.
// Optional VGA_SYNC_ALIGN_EN delays hsync/vsync by one pixel period to match registered rgb.
module vga_sync_gen #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter int unsigned SYNC_POL  = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        p_tick,
  output logic [10:0] pixel_x,
  output logic [10:0] pixel_y,
  output logic        video_on,
  output logic        hsync,
  output logic        vsync,
  output logic        line_start,
  output logic        frame_start
);
  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned DW      = $clog2(CLK_DIV);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_DISP = 11'(H_DISPLAY);
  localparam logic [10:0] V_DISP = 11'(V_DISPLAY);
  localparam logic [10:0] HS_BEG = 11'(H_DISPLAY + H_FRONT);
  localparam logic [10:0] HS_END = 11'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [10:0] VS_BEG = 11'(V_DISPLAY + V_FRONT);
  localparam logic [10:0] VS_END = 11'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic        ACT    = 1'(SYNC_POL);

  logic [DW-1:0] div_q, div_d;
  logic [10:0]   h_q, h_d, v_q, v_d;
  logic          step;
  logic          tick_q, von_q, von_d, hs_q, hs_d, vs_q, vs_d;
  logic          ls_q, ls_d, fs_q, fs_d;

  // Decode from the next position so every output lands on the same clk as the step.
  always_comb begin
    step  = (div_q == DIV_LAST);
    div_d = step ? '0 : div_q + DW'(1);
    h_d   = h_q;
    v_d   = v_q;
    if (step) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 11'd1;
      end else begin
        h_d = h_q + 11'd1;
      end
    end
    von_d = (h_d < H_DISP) && (v_d < V_DISP);
    hs_d  = ((h_d >= HS_BEG) && (h_d <= HS_END)) ? ACT : ~ACT;
    vs_d  = ((v_d >= VS_BEG) && (v_d <= VS_END)) ? ACT : ~ACT;
    ls_d  = step && (h_d == '0);
    fs_d  = ls_d && (v_d == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q  <= '0;
      h_q    <= '0;
      v_q    <= '0;
      tick_q <= 1'b0;
      von_q  <= 1'b0;
      hs_q   <= ~ACT;
      vs_q   <= ~ACT;
      ls_q   <= 1'b0;
      fs_q   <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= step;
      ls_q   <= ls_d;
      fs_q   <= fs_d;
      if (step) begin
        h_q   <= h_d;
        v_q   <= v_d;
        von_q <= von_d;
        hs_q  <= hs_d;
        vs_q  <= vs_d;
      end
    end
  end

`ifdef VGA_SYNC_ALIGN_EN
  logic hs2_q, vs2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs2_q <= ~ACT;
      vs2_q <= ~ACT;
    end else if (step) begin
      hs2_q <= hs_q;
      vs2_q <= vs_q;
    end
  end

  assign hsync = hs2_q;
  assign vsync = vs2_q;
`else
  assign hsync = hs_q;
  assign vsync = vs_q;
`endif

  assign p_tick      = tick_q;
  assign pixel_x     = h_q;
  assign pixel_y     = v_q;
  assign video_on    = von_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen on a shrunken 15x10 raster so full frames stay short.
module tb_vga_sync_gen;
  localparam int DIV = 4;
  localparam int HD = 8, HF = 2, HS = 3, HB = 2;
  localparam int VD = 6, VF = 1, VS = 2, VB = 1;
  localparam int HT = HD + HF + HS + HB;   // 15
  localparam int VT = VD + VF + VS + VB;   // 10
  localparam int FRAME = HT * VT;          // 150 ticks
  localparam logic SP = 1'b0;
`ifdef VGA_SYNC_ALIGN_EN
  localparam int SH = 1;
`else
  localparam int SH = 0;
`endif

  logic        clk, reset_n;
  logic        p_tick, video_on, hsync, vsync, line_start, frame_start;
  logic [10:0] pixel_x, pixel_y;

  int errs = 0;
  int checks = 0;
  int von_cnt, hs_cnt, vs_cnt, ls_cnt, fs_cnt;

  vga_sync_gen #(
    .CLK_DIV(DIV), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_POL(0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .p_tick(p_tick), .pixel_x(pixel_x),
    .pixel_y(pixel_y), .video_on(video_on), .hsync(hsync), .vsync(vsync),
    .line_start(line_start), .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sync activity of the position reached after n ticks (n = 0 is the reset state).
  function automatic logic h_act(int n);
    int x;
    if (n <= 0) return 1'b0;
    x = n % HT;
    return (x >= HD + HF) && (x <= HD + HF + HS - 1);
  endfunction

  function automatic logic v_act(int n);
    int y;
    if (n <= 0) return 1'b0;
    y = (n / HT) % VT;
    return (y >= VD + VF) && (y <= VD + VF + VS - 1);
  endfunction

  // Expected {p_tick, x, y, video_on, hsync, vsync, line_start, frame_start} c clks after release.
  function automatic logic [27:0] exp_vec(int c);
    int n, x, y;
    logic tk, von, ls, fs, hs, vs;
    n  = c / DIV;
    tk = (c % DIV == 0) && (c > 0);
    if (n == 0) return {1'b0, 11'd0, 11'd0, 1'b0, ~SP, ~SP, 1'b0, 1'b0};
    x   = n % HT;
    y   = (n / HT) % VT;
    von = (x < HD) && (y < VD);
    ls  = tk && (x == 0);
    fs  = ls && (y == 0);
    hs  = h_act(n - SH) ? SP : ~SP;
    vs  = v_act(n - SH) ? SP : ~SP;
    return {tk, 11'(x), 11'(y), von, hs, vs, ls, fs};
  endfunction

  task automatic release_rst();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Starts at the negedge of release; compares every output on each of nclk clks.
  task automatic sweep(input int nclk);
    logic [27:0] obs, exp;
    von_cnt = 0; hs_cnt = 0; vs_cnt = 0; ls_cnt = 0; fs_cnt = 0;
    for (int c = 1; c <= nclk; c++) begin
      @(posedge clk);
      #1;
      obs = {p_tick, pixel_x, pixel_y, video_on, hsync, vsync, line_start, frame_start};
      exp = exp_vec(c);
      checks++;
      if (obs !== exp) begin
        errs++;
        $display("FAIL sweep clk=%0d got=%h exp=%h", c, obs, exp);
      end
      if (p_tick && (c / DIV) <= FRAME) begin
        if (video_on) von_cnt++;
        if (hsync == SP) hs_cnt++;
        if (vsync == SP) vs_cnt++;
      end
      if (line_start) ls_cnt++;
      if (frame_start) fs_cnt++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (p_tick !== 1'b0)      begin errs++; $display("FAIL rst_p_tick got=%b exp=0", p_tick); end
    checks++; if (pixel_x !== 11'd0)    begin errs++; $display("FAIL rst_pixel_x got=%0d exp=0", pixel_x); end
    checks++; if (pixel_y !== 11'd0)    begin errs++; $display("FAIL rst_pixel_y got=%0d exp=0", pixel_y); end
    checks++; if (video_on !== 1'b0)    begin errs++; $display("FAIL rst_video_on got=%b exp=0", video_on); end
    checks++; if (hsync !== ~SP)        begin errs++; $display("FAIL rst_hsync got=%b exp=%b", hsync, ~SP); end
    checks++; if (vsync !== ~SP)        begin errs++; $display("FAIL rst_vsync got=%b exp=%b", vsync, ~SP); end
    checks++; if (line_start !== 1'b0)  begin errs++; $display("FAIL rst_line_start got=%b exp=0", line_start); end
    checks++; if (frame_start !== 1'b0) begin errs++; $display("FAIL rst_frame_start got=%b exp=0", frame_start); end
  endtask

  task automatic test_first_tick();
    int c;
    c = 0;
    release_rst();
    while (c < 10 && p_tick !== 1'b1) begin
      @(posedge clk);
      #1;
      c++;
    end
    checks++; if (c !== DIV)           begin errs++; $display("FAIL first_tick_latency got=%0d exp=%0d", c, DIV); end
    checks++; if (pixel_x !== 11'd1)   begin errs++; $display("FAIL first_tick_x got=%0d exp=1", pixel_x); end
    checks++; if (pixel_y !== 11'd0)   begin errs++; $display("FAIL first_tick_y got=%0d exp=0", pixel_y); end
    checks++; if (video_on !== 1'b1)   begin errs++; $display("FAIL first_tick_video_on got=%b exp=1", video_on); end
    checks++; if (line_start !== 1'b0) begin errs++; $display("FAIL first_tick_line_start got=%b exp=0", line_start); end
    @(posedge clk);
    #1;
    checks++; if (p_tick !== 1'b0)     begin errs++; $display("FAIL tick_duty got=%b exp=0", p_tick); end
    checks++; if (pixel_x !== 11'd1)   begin errs++; $display("FAIL x_hold got=%0d exp=1", pixel_x); end
  endtask

  task automatic test_frame();
    @(negedge clk);
    reset_n = 1'b0;
    release_rst();
    sweep(FRAME * DIV + 2 * DIV);
    checks++; if (von_cnt !== HD * VD)  begin errs++; $display("FAIL frame_video_on_ticks got=%0d exp=%0d", von_cnt, HD * VD); end
    checks++; if (hs_cnt !== HS * VT)   begin errs++; $display("FAIL frame_hsync_ticks got=%0d exp=%0d", hs_cnt, HS * VT); end
    checks++; if (vs_cnt !== VS * HT)   begin errs++; $display("FAIL frame_vsync_ticks got=%0d exp=%0d", vs_cnt, VS * HT); end
    checks++; if (ls_cnt !== VT)        begin errs++; $display("FAIL frame_line_starts got=%0d exp=%0d", ls_cnt, VT); end
    checks++; if (fs_cnt !== 1)         begin errs++; $display("FAIL frame_frame_starts got=%0d exp=1", fs_cnt); end
  endtask

  // Reset lands at pixel (11,7): inside both sync pulses, between ticks.
  task automatic test_reset_mid();
    @(negedge clk);
    reset_n = 1'b0;
    release_rst();
    sweep((7 * HT + 11) * DIV + 2);
    checks++; if (pixel_x !== 11'd11) begin errs++; $display("FAIL mid_pos_x got=%0d exp=11", pixel_x); end
    checks++; if (pixel_y !== 11'd7)  begin errs++; $display("FAIL mid_pos_y got=%0d exp=7", pixel_y); end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++; if (hsync !== ~SP)      begin errs++; $display("FAIL mid_rst_hsync got=%b exp=%b", hsync, ~SP); end
    checks++; if (vsync !== ~SP)      begin errs++; $display("FAIL mid_rst_vsync got=%b exp=%b", vsync, ~SP); end
    checks++; if (pixel_x !== 11'd0)  begin errs++; $display("FAIL mid_rst_x got=%0d exp=0", pixel_x); end
    checks++; if (pixel_y !== 11'd0)  begin errs++; $display("FAIL mid_rst_y got=%0d exp=0", pixel_y); end
    checks++; if (video_on !== 1'b0)  begin errs++; $display("FAIL mid_rst_video_on got=%b exp=0", video_on); end
    repeat (2) @(posedge clk);
    release_rst();
    sweep(6 * DIV);
  endtask

  initial begin
    reset_n = 1'b0;
    if (HT >= 2048 || VT >= 2048) begin
      $display("FAIL param_sum ht=%0d vt=%0d limit=2048", HT, VT);
      $fatal(1);
    end
    test_reset();
    test_first_tick();
    test_frame();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
